// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS writeback stage.
//   load_size_e : width selector for load extraction (3 is reserved, treated as word)
//   REG_ZERO    : index of the hard-wired zero register
//   XLEN_DEF    : default datapath width
package mips_pkg;

  localparam int unsigned XLEN_DEF = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    LS_BYTE = 2'd0,
    LS_HALF = 2'd1,
    LS_WORD = 2'd2
  } load_size_e;

endpackage

// File: rtl/load_align.sv
// Combinational load-data extraction for lb/lbu/lh/lhu/lw.
//   mem_rdata_i     : aligned data word from memory
//   offset_i        : byte offset within the word (address[1:0])
//   load_size_i     : byte / half / word (reserved encoding behaves as word)
//   load_unsigned_i : zero-extend instead of sign-extend
//   data_o          : extracted and extended load value
//   misaligned_o    : access does not sit on its natural boundary
module load_align
  import mips_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic [1:0]      offset_i,
  input  load_size_e      load_size_i,
  input  logic            load_unsigned_i,
  output logic [XLEN-1:0] data_o,
  output logic            misaligned_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Little-endian lanes: byte lane = offset, half lane = offset[1].
  assign byte_lane = mem_rdata_i[{offset_i, 3'b000} +: 8];
  assign half_lane = mem_rdata_i[{offset_i[1], 4'b0000} +: 16];

  always_comb begin
    data_o       = mem_rdata_i;
    misaligned_o = 1'b0;
    case (load_size_i)
      LS_BYTE: begin
        data_o = {{(XLEN-8){byte_lane[7] & ~load_unsigned_i}}, byte_lane};
      end
      LS_HALF: begin
        data_o       = {{(XLEN-16){half_lane[15] & ~load_unsigned_i}}, half_lane};
        misaligned_o = offset_i[0];
      end
      default: begin
        data_o       = mem_rdata_i;
        misaligned_o = (offset_i != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mips_writeback.sv
// MIPS writeback stage: MEM/WB pipeline register, result selection and
// register-file write port, plus a retired-instruction counter.
//   Inputs : in_valid/stall/flush control, alu_result, mem_rdata, pc_plus8,
//            dest_reg, reg_write, mem_to_reg, link, load_size, load_unsigned
//   Outputs: write_data/write_register/regwrite (register file write port),
//            wb_valid, misalign_err, retire_count
module mips_writeback
  import mips_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [XLEN-1:0]  alu_result_i,
  input  logic [XLEN-1:0]  mem_rdata_i,
  input  logic [XLEN-1:0]  pc_plus8_i,
  input  logic [4:0]       dest_reg_i,
  input  logic             reg_write_i,
  input  logic             mem_to_reg_i,
  input  logic             link_i,
  input  logic [1:0]       load_size_i,
  input  logic             load_unsigned_i,
  output logic [XLEN-1:0]  write_data_o,
  output logic [4:0]       write_register_o,
  output logic             regwrite_o,
  output logic             wb_valid_o,
  output logic             misalign_err_o,
  output logic [CNT_W-1:0] retire_count_o
);

  logic [XLEN-1:0]  ld_data;
  logic             ld_misaligned;
  logic [XLEN-1:0]  result;
  logic             entry_valid;

  logic [XLEN-1:0]  write_data_q, write_data_d;
  logic [4:0]       write_register_q, write_register_d;
  logic             reg_write_q, reg_write_d;
  logic             wb_valid_q, wb_valid_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] retire_q, retire_d;

  load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .mem_rdata_i     (mem_rdata_i),
    .offset_i        (alu_result_i[1:0]),
    .load_size_i     (load_size_e'(load_size_i)),
    .load_unsigned_i (load_unsigned_i),
    .data_o          (ld_data),
    .misaligned_o    (ld_misaligned)
  );

  assign entry_valid = in_valid_i & ~flush_i;

  // link has priority over mem_to_reg.
  always_comb begin
    result = alu_result_i;
    if (link_i) begin
      result = pc_plus8_i;
    end else if (mem_to_reg_i) begin
      result = ld_data;
    end
  end

  always_comb begin
    write_data_d     = write_data_q;
    write_register_d = write_register_q;
    reg_write_d      = reg_write_q;
    wb_valid_d       = wb_valid_q;
    misalign_d       = misalign_q;
    retire_d         = retire_q;
    if (!stall_i) begin
      write_data_d     = result;
      write_register_d = dest_reg_i;
      reg_write_d      = reg_write_i;
      wb_valid_d       = entry_valid;
      misalign_d       = entry_valid & mem_to_reg_i & ld_misaligned;
      if (entry_valid) begin
        retire_d = retire_q + CNT_W'(1);
      end
    end else if (flush_i) begin
      // Flush squashes the held entry even while stalled.
      wb_valid_d = 1'b0;
      misalign_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      write_data_q     <= '0;
      write_register_q <= '0;
      reg_write_q      <= 1'b0;
      wb_valid_q       <= 1'b0;
      misalign_q       <= 1'b0;
      retire_q         <= '0;
    end else begin
      write_data_q     <= write_data_d;
      write_register_q <= write_register_d;
      reg_write_q      <= reg_write_d;
      wb_valid_q       <= wb_valid_d;
      misalign_q       <= misalign_d;
      retire_q         <= retire_d;
    end
  end

  assign write_data_o     = write_data_q;
  assign write_register_o = write_register_q;
  assign wb_valid_o       = wb_valid_q;
  assign misalign_err_o   = misalign_q;
  assign retire_count_o   = retire_q;
  assign regwrite_o       = wb_valid_q & reg_write_q & ~misalign_q &
                            (write_register_q != REG_ZERO);

endmodule

// File: tb/tb_mips_writeback.sv
module tb_mips_writeback;

  logic        clk_i;
  logic        rst_ni;
  logic        in_valid_i, stall_i, flush_i;
  logic [31:0] alu_result_i, mem_rdata_i, pc_plus8_i;
  logic [4:0]  dest_reg_i;
  logic        reg_write_i, mem_to_reg_i, link_i;
  logic [1:0]  load_size_i;
  logic        load_unsigned_i;
  logic [31:0] write_data_o;
  logic [4:0]  write_register_o;
  logic        regwrite_o, wb_valid_o, misalign_err_o;
  logic [31:0] retire_count_o;

  int unsigned vectors;
  int unsigned miscompares;

  // Reference model state: what the stage should hold after each edge.
  logic [31:0] m_wd;
  logic [4:0]  m_wr;
  logic        m_rw, m_valid, m_mis;
  logic [31:0] m_cnt;

  mips_writeback #(
    .XLEN  (32),
    .CNT_W (32)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .in_valid_i       (in_valid_i),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .alu_result_i     (alu_result_i),
    .mem_rdata_i      (mem_rdata_i),
    .pc_plus8_i       (pc_plus8_i),
    .dest_reg_i       (dest_reg_i),
    .reg_write_i      (reg_write_i),
    .mem_to_reg_i     (mem_to_reg_i),
    .link_i           (link_i),
    .load_size_i      (load_size_i),
    .load_unsigned_i  (load_unsigned_i),
    .write_data_o     (write_data_o),
    .write_register_o (write_register_o),
    .regwrite_o       (regwrite_o),
    .wb_valid_o       (wb_valid_o),
    .misalign_err_o   (misalign_err_o),
    .retire_count_o   (retire_count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Load value from plain shift-and-mask arithmetic.
  function automatic logic [31:0] load_value(input logic [31:0] rd, input logic [1:0] off,
                                             input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rd >> (8 * int'(off))) & 32'h0000_00FF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (rd >> (16 * int'(off[1]))) & 32'h0000_FFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] off, input logic [1:0] sz);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return (off % 2) != 0;
    return off != 2'd0;
  endfunction

  task automatic model_reset();
    m_wd = '0; m_wr = '0; m_rw = 1'b0; m_valid = 1'b0; m_mis = 1'b0; m_cnt = '0;
  endtask

  task automatic model_edge();
    logic live;
    live = in_valid_i && !flush_i;
    if (!stall_i) begin
      if (link_i) m_wd = pc_plus8_i;
      else if (mem_to_reg_i)
        m_wd = load_value(mem_rdata_i, alu_result_i[1:0], load_size_i, load_unsigned_i);
      else m_wd = alu_result_i;
      m_wr    = dest_reg_i;
      m_rw    = reg_write_i;
      m_valid = live;
      m_mis   = live && mem_to_reg_i && is_misaligned(alu_result_i[1:0], load_size_i);
      if (live) m_cnt = m_cnt + 32'd1;
    end else if (flush_i) begin
      m_valid = 1'b0;
      m_mis   = 1'b0;
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic exp_rw;
    exp_rw = m_valid && m_rw && !m_mis && (m_wr != 5'd0);
    chk32({tag, ".write_data"}, write_data_o, m_wd);
    chk32({tag, ".write_register"}, {27'd0, write_register_o}, {27'd0, m_wr});
    chk32({tag, ".regwrite"}, {31'd0, regwrite_o}, {31'd0, exp_rw});
    chk32({tag, ".wb_valid"}, {31'd0, wb_valid_o}, {31'd0, m_valid});
    chk32({tag, ".misalign_err"}, {31'd0, misalign_err_o}, {31'd0, m_mis});
    chk32({tag, ".retire_count"}, retire_count_o, m_cnt);
  endtask

  task automatic drive(input logic v, input logic st, input logic fl, input logic [31:0] alu,
                       input logic [31:0] rd, input logic [31:0] pc8, input logic [4:0] d,
                       input logic rw, input logic m2r, input logic lk, input logic [1:0] ls,
                       input logic us);
    in_valid_i = v; stall_i = st; flush_i = fl; alu_result_i = alu; mem_rdata_i = rd;
    pc_plus8_i = pc8; dest_reg_i = d; reg_write_i = rw; mem_to_reg_i = m2r; link_i = lk;
    load_size_i = ls; load_unsigned_i = us;
  endtask

  // Inputs are driven at the falling edge; one rising edge; check at the next falling edge.
  task automatic tick(input string tag);
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
    check_all(tag);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_ni = 1'b0;
    drive(0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 2'd0, 0);
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    check_all("reset");
    rst_ni = 1'b1;

    // ALU write.
    drive(1, 0, 0, 32'h1234_5678, 32'h0, 32'h0, 5'd10, 1, 0, 0, 2'd2, 0);
    tick("alu");
    // Byte and half loads.
    drive(1, 0, 0, 32'h0000_1003, 32'h80FF_7F01, 32'h0, 5'd5, 1, 1, 0, 2'd0, 0);
    tick("lb");
    drive(1, 0, 0, 32'h0000_1003, 32'h80FF_7F01, 32'h0, 5'd5, 1, 1, 0, 2'd0, 1);
    tick("lbu");
    drive(1, 0, 0, 32'h0000_1002, 32'h80FF_7F01, 32'h0, 5'd6, 1, 1, 0, 2'd1, 0);
    tick("lh");
    drive(1, 0, 0, 32'h0000_1002, 32'h80FF_7F01, 32'h0, 5'd6, 1, 1, 0, 2'd1, 1);
    tick("lhu");
    // Misaligned word then aligned word.
    drive(1, 0, 0, 32'h0000_2001, 32'hCAFE_BABE, 32'h0, 5'd7, 1, 1, 0, 2'd2, 0);
    tick("lw_mis");
    drive(1, 0, 0, 32'h0000_2004, 32'hCAFE_BABE, 32'h0, 5'd7, 1, 1, 0, 2'd2, 0);
    tick("lw_ok");
    // Reserved size behaves as word.
    drive(1, 0, 0, 32'h0000_2002, 32'h1122_3344, 32'h0, 5'd8, 1, 1, 0, 2'd3, 0);
    tick("ls3_mis");
    // Write to $0 suppressed; link has priority.
    drive(1, 0, 0, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd0, 1, 0, 0, 2'd2, 0);
    tick("reg0");
    drive(1, 0, 0, 32'h0000_0003, 32'h5555_5555, 32'h0040_0010, 5'd31, 1, 1, 1, 2'd2, 0);
    tick("link");
    // Stall for three cycles: new inputs ignored.
    drive(1, 1, 0, 32'h7777_7777, 32'h0, 32'h0, 5'd3, 1, 0, 0, 2'd2, 0);
    tick("stall1");
    tick("stall2");
    tick("stall3");
    // Flush dominates stall.
    drive(1, 1, 1, 32'h7777_7777, 32'h0, 32'h0, 5'd3, 1, 0, 0, 2'd2, 0);
    tick("stall_flush");
    drive(1, 0, 1, 32'h6666_6666, 32'h0, 32'h0, 5'd4, 1, 0, 0, 2'd2, 0);
    tick("flush");

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0), $urandom, $urandom, $urandom,
            5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)), 1'($urandom));
      tick("rand");
    end

    // Async reset between edges while a write is pending.
    drive(1, 0, 0, 32'hA5A5_A5A5, 32'h0, 32'h0, 5'd12, 1, 0, 0, 2'd2, 0);
    tick("pre_reset");
    drive(1, 1, 1, 32'h0, 32'h0, 32'h0, 5'd12, 1, 0, 0, 2'd2, 0);
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 2'd0, 0);
    tick("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
